// File: rtl/rf_sb_if.sv
// Register file / scoreboard bundle between decode, writeback and rf_sb.
// master = decode + writeback side, slave = register file.
interface rf_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // read side
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic              ra_used;
  logic              rb_used;
  logic [DATA_W-1:0] busA;
  logic [DATA_W-1:0] busB;
  logic              ra_busy;
  logic              rb_busy;
  logic              stall;
  // issue side
  logic              iss_en;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_busy;
  // writeback side
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              link_en;
  logic [DATA_W-1:0] cur_pc;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output ra, rb, ra_used, rb_used, iss_en, iss_rd,
           wr_en, wr_addr, wr_data, link_en, cur_pc,
    input  busA, busB, ra_busy, rb_busy, stall, iss_busy, pend_cnt
  );

  modport slave (
    input  ra, rb, ra_used, rb_used, iss_en, iss_rd,
           wr_en, wr_addr, wr_data, link_en, cur_pc,
    output busA, busB, ra_busy, rb_busy, stall, iss_busy, pend_cnt
  );
endinterface

// File: rtl/rf_sb.sv
// rf_sb: 2R/1W register file with link (PC+inc) writes and a per-register
// pending-write scoreboard for RAW/WAW stall detection.
// Optional macro RF_BYPASS_EN: forward this cycle's writeback data to the
// read ports and hide the busy flag of the register being written.
module rf_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int LINK_REG = 31,
  parameter int PC_INC   = 4
) (
  input logic   clk,
  input logic   rst_n,
  rf_sb_if.slave sb
);

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     pend_q, pend_d;

  logic [ADDR_W-1:0]   wd;
  logic [DATA_W-1:0]   wdata;
  logic                wr_ok;
  logic                iss_ok;

  // Address names a real, writable register (r0 is hardwired zero).
  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < 32'(NUM_REGS));
  endfunction

  // Effective writeback destination and data; link writes redirect to LINK_REG.
  always_comb begin
    wd     = sb.link_en ? LINK_A : sb.wr_addr;
    wdata  = sb.link_en ? sb.cur_pc + DATA_W'(PC_INC) : sb.wr_data;
    wr_ok  = sb.wr_en && in_rng(wd);
    iss_ok = sb.iss_en && in_rng(sb.iss_rd);
  end

  // Same-cycle write hit on a read address (only meaningful with bypass).
  function automatic logic byp_hit(input logic [ADDR_W-1:0] a);
    return BYPASS && wr_ok && (a == wd);
  endfunction

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    if (!in_rng(a))  return '0;
    if (byp_hit(a))  return wdata;
    return regs_q[a];
  endfunction

  function automatic logic bsy(input logic [ADDR_W-1:0] a);
    if (!in_rng(a))  return 1'b0;
    if (byp_hit(a))  return 1'b0;
    return busy_q[a];
  endfunction

  // Combinational read ports, busy flags and stall.
  always_comb begin
    sb.busA     = rd(sb.ra);
    sb.busB     = rd(sb.rb);
    sb.ra_busy  = bsy(sb.ra);
    sb.rb_busy  = bsy(sb.rb);
    sb.iss_busy = bsy(sb.iss_rd);
    sb.stall    = (sb.ra_used & sb.ra_busy) | (sb.rb_used & sb.rb_busy) |
                  (sb.iss_en & sb.iss_busy);
    sb.pend_cnt = pend_q;
  end

  // Scoreboard next state: clear on writeback, then set on issue so a
  // same-register issue keeps the mark for the new producer.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[wd] = 1'b0;
    if (iss_ok) busy_d[sb.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    pend_d = '0;
    for (int i = 0; i < NUM_REGS; i++) pend_d = pend_d + (ADDR_W+1)'(busy_d[i]);
  end

  // Scoreboard state and pending count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  // Register storage; r0 and out-of-range destinations are never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wd] <= wdata;
    end
  end

endmodule

// File: tb/tb_rf_sb.sv
// Bench for rf_sb: reference model + expectation queue; each cycle pushes
// model and directed expectations, then pops and compares after settling.
module tb_rf_sb;
  localparam int DW = 32, AW = 5, NR = 32, LR = 31, PI = 4;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  rf_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .LINK_REG(LR), .PC_INC(PI))
    dut (.clk(clk), .rst_n(rst_n), .sb(bus));

  typedef enum int {S_BUSA, S_BUSB, S_RAB, S_RBB, S_ISB, S_STALL, S_PEND} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   errs = 0, nchk = 0;

  logic [DW-1:0] m_reg [NR];
  bit            m_busy [NR];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] obs(input sel_e s);
    case (s)
      S_BUSA:  return 64'(bus.busA);
      S_BUSB:  return 64'(bus.busB);
      S_RAB:   return 64'(bus.ra_busy);
      S_RBB:   return 64'(bus.rb_busy);
      S_ISB:   return 64'(bus.iss_busy);
      S_STALL: return 64'(bus.stall);
      default: return 64'(bus.pend_cnt);
    endcase
  endfunction

  // ---- reference model ----
  function automatic int m_wd();
    return bus.link_en ? LR : int'(bus.wr_addr);
  endfunction

  function automatic logic [DW-1:0] m_wdata();
    logic [DW-1:0] v;
    v = bus.link_en ? bus.cur_pc + 32'(PI) : bus.wr_data;
    return v;
  endfunction

  function automatic bit m_wok();
    return bus.wr_en && m_wd() != 0 && m_wd() < NR;
  endfunction

  function automatic logic [DW-1:0] m_rd(input int a);
    if (a == 0 || a >= NR) return '0;
    if (BYP && m_wok() && a == m_wd()) return m_wdata();
    return m_reg[a];
  endfunction

  function automatic bit m_bsy(input int a);
    if (a == 0 || a >= NR) return 1'b0;
    if (BYP && m_wok() && a == m_wd()) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int m_pend();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
  endtask

  task automatic m_clock();
    int wd = m_wd();
    if (m_wok()) m_reg[wd] = m_wdata();
    if (bus.wr_en && wd < NR) m_busy[wd] = 1'b0;
    if (bus.iss_en && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
  endtask

  task automatic expv(input string tag, input sel_e s, input logic [63:0] v);
    exp_t e;
    e.tag = tag; e.sel = s; e.exp = v;
    q.push_back(e);
  endtask

  task automatic push_model(input string tag);
    bit st;
    st = (bus.ra_used && m_bsy(bus.ra)) || (bus.rb_used && m_bsy(bus.rb)) ||
         (bus.iss_en && m_bsy(bus.iss_rd));
    expv({tag, ".busA"},  S_BUSA,  64'(m_rd(bus.ra)));
    expv({tag, ".busB"},  S_BUSB,  64'(m_rd(bus.rb)));
    expv({tag, ".raB"},   S_RAB,   64'(m_bsy(bus.ra)));
    expv({tag, ".rbB"},   S_RBB,   64'(m_bsy(bus.rb)));
    expv({tag, ".issB"},  S_ISB,   64'(m_bsy(bus.iss_rd)));
    expv({tag, ".stall"}, S_STALL, 64'(st));
    expv({tag, ".pend"},  S_PEND,  64'(m_pend()));
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic look(input string tag);
    push_model(tag);
    #1;
    drain();
  endtask

  // One clock: check settled outputs, advance model on the edge, return at negedge.
  task automatic cyc(input string tag);
    look(tag);
    @(posedge clk);
    m_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.ra = '0; bus.rb = '0; bus.ra_used = 0; bus.rb_used = 0;
    bus.iss_en = 0; bus.iss_rd = '0; bus.wr_en = 0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.link_en = 0; bus.cur_pc = '0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    bus.wr_en = 1; bus.wr_addr = AW'(a); bus.wr_data = d;
  endtask

  initial begin
    idle();
    m_reset();
    // reset
    #12;
    look("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.ra = AW'(i * 4 + 1); bus.rb = AW'(31 - i * 3);
      expv("rst_a0", S_BUSA, 64'h0);
      expv("rst_pend", S_PEND, 64'h0);
      expv("rst_stall", S_STALL, 64'h0);
      cyc("rst");
    end

    // write and r0
    idle(); wr(5, 32'hDEADBEEF); bus.ra = 5; cyc("w5");
    idle(); bus.ra = 5; expv("rd5", S_BUSA, 64'hDEADBEEF); cyc("rd5");
    idle(); wr(0, 32'h1234); bus.ra = 0; cyc("w0");
    idle(); bus.ra = 0; expv("rd0", S_BUSA, 64'h0); cyc("rd0");

    // link writes
    idle(); wr(7, 32'h1111); bus.link_en = 1; bus.cur_pc = 32'h0040_0010; cyc("lnk1");
    idle(); bus.ra = 31; bus.rb = 7;
    expv("lnk1_r31", S_BUSA, 64'h0040_0014); expv("lnk1_r7", S_BUSB, 64'h0); cyc("lnk1r");
    idle(); wr(7, 32'h2222); bus.link_en = 1; bus.cur_pc = 32'hFFFF_FFFC; cyc("lnk2");
    idle(); bus.ra = 31; expv("lnk2_wrap", S_BUSA, 64'h0); cyc("lnk2r");
    idle(); bus.link_en = 1; bus.cur_pc = 32'h100; cyc("lnk_nowr");
    idle(); bus.ra = 31; expv("lnk_nowr", S_BUSA, 64'h0); cyc("lnk_nowr_r");

    // RAW hazard on r9
    idle(); bus.iss_en = 1; bus.iss_rd = 9; cyc("iss9");
    idle(); bus.ra = 9; bus.ra_used = 1;
    expv("haz_pend", S_PEND, 64'd1); expv("haz_stall", S_STALL, 64'd1); cyc("haz");
    idle(); bus.ra = 9; bus.ra_used = 1; wr(9, 32'h55AA);
    expv("wb_stall", S_STALL, BYP ? 64'd0 : 64'd1);
    if (BYP) expv("wb_byp", S_BUSA, 64'h55AA);
    cyc("wb9");
    idle(); bus.ra = 9; bus.ra_used = 1;
    expv("post_stall", S_STALL, 64'd0); expv("post_a", S_BUSA, 64'h55AA);
    expv("post_pend", S_PEND, 64'd0); cyc("post9");

    // simultaneous issue + writeback on r3
    idle(); bus.iss_en = 1; bus.iss_rd = 3; cyc("iss3");
    idle(); bus.iss_en = 1; bus.iss_rd = 3; wr(3, 32'h77); cyc("iw3");
    idle(); bus.ra = 3; bus.iss_en = 1; bus.iss_rd = 3;
    expv("iw_pend", S_PEND, 64'd1); expv("iw_busy", S_RAB, 64'd1);
    expv("waw_b", S_ISB, 64'd1); expv("waw_st", S_STALL, 64'd1); cyc("waw3");
    idle(); wr(3, 32'h88); cyc("clr3");
    idle(); expv("clr_pend", S_PEND, 64'd0); cyc("clr3p");

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      idle();
      bus.ra = AW'($urandom_range(0, 31)); bus.rb = AW'($urandom_range(0, 31));
      bus.ra_used = 1'($urandom); bus.rb_used = 1'($urandom);
      bus.iss_en = ($urandom_range(0, 2) != 0); bus.iss_rd = AW'($urandom_range(0, 31));
      bus.wr_en = 1'($urandom); bus.wr_addr = AW'($urandom_range(0, 31));
      bus.wr_data = $urandom; bus.link_en = ($urandom_range(0, 7) == 0);
      bus.cur_pc = $urandom;
      cyc("rnd");
    end
    idle();
    for (int n = 0; n < 40; n++) begin
      bus.wr_en = 1; bus.wr_addr = AW'(n % 32); bus.wr_data = $urandom;
      cyc("drain");
    end
    idle(); expv("drain_pend", S_PEND, 64'd0); cyc("drain_p");

    // async reset mid-flight
    idle(); wr(4, 32'h4444); cyc("w4");
    idle(); bus.iss_en = 1; bus.iss_rd = 4; cyc("i4");
    idle(); bus.iss_en = 1; bus.iss_rd = 8; cyc("i8");
    idle(); bus.iss_en = 1; bus.iss_rd = 12; cyc("i12");
    idle(); bus.ra = 4; bus.rb = 8; bus.ra_used = 1;
    expv("pre_pend", S_PEND, 64'd3); expv("pre_r4", S_BUSA, 64'h4444);
    look("pre_rst");
    #1;
    rst_n = 1'b0;
    #1;
    m_reset();
    bus.iss_rd = 12;
    expv("ar_pend", S_PEND, 64'd0); expv("ar_r4", S_BUSA, 64'h0);
    expv("ar_rab", S_RAB, 64'd0); expv("ar_rbb", S_RBB, 64'd0);
    expv("ar_isb", S_ISB, 64'd0); expv("ar_stall", S_STALL, 64'd0);
    look("ar");
    @(negedge clk);
    rst_n = 1'b1;
    idle(); bus.ra = 4; cyc("after_rst");

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
